// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared debounce state encoding and default timing
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizer, stability counter and press strobe for one button
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NB_COUNT        = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic I_clk,
    input  logic reset_button,
    input  logic I_button,
    output logic O_level,
    output logic O_pulse
);

    localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_COUNT-1:0] ONE  = NB_COUNT'(1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    state_t              state_q, state_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic                level_q, level_d;
    logic                pulse_q, pulse_d;

    // two-flop synchronizer feed; only sync2 is trusted by the debouncer
    always_comb begin
        sync1_d = I_button;
        sync2_d = sync1_q;
    end

    // candidate states count consecutive matching samples; a mismatch drops back
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync2_q) begin
                    state_d = ST_WAIT_HIGH;
                    count_d = ONE;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d = ST_LOW;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    state_d = ST_HIGH;
                    count_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            ST_HIGH: begin
                if (!sync2_q) begin
                    state_d = ST_WAIT_LOW;
                    count_d = ONE;
                end
            end
            ST_WAIT_LOW: begin
                if (sync2_q) begin
                    state_d = ST_HIGH;
                    count_d = '0;
                end else if (count_q == LAST) begin
                    state_d = ST_LOW;
                    count_d = '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                count_d = '0;
            end
        endcase
        level_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
    end

    // all channel state clears immediately on reset, discarding any press in progress
    always_ff @(posedge I_clk or posedge reset_button) begin
        if (reset_button) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_LOW;
            count_q <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign O_level = level_q;
    assign O_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: independent debounced level and press strobe per button
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                 I_clk,
    input  logic                 reset_button,
    input  logic [N_BUTTONS-1:0] I_button,
    output logic [N_BUTTONS-1:0] O_level,
    output logic [N_BUTTONS-1:0] O_pulse
);

    localparam int NB_COUNT = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .NB_COUNT       (NB_COUNT)
        ) u_ch (
            .I_clk       (I_clk),
            .reset_button(reset_button),
            .I_button    (I_button[i]),
            .O_level     (O_level[i]),
            .O_pulse     (O_pulse[i])
        );
    end

endmodule
